// File: rtl/display_pkg.sv
// Shared definitions for the character display command interface:
// command codes, data field layout and default grid geometry.
package display_pkg;

    typedef enum logic [3:0] {
        CMD_NOP       = 4'd0,
        CMD_SCROLL    = 4'd1,
        CMD_POS_CLEAR = 4'd2,
        CMD_NUMBER    = 4'd3
    } cmd_e;

    // Field positions inside the 48-bit command data word.
    localparam int X_MSB   = 47;
    localparam int X_LSB   = 40;
    localparam int Y_MSB   = 39;
    localparam int Y_LSB   = 32;
    localparam int NUM_MSB = 31;
    localparam int NUM_LSB = 0;

    // Pixel width of one number cell; the display multiplies col by this.
    localparam int CELL_WIDTH = 12;

    localparam int DEF_COLS    = 13;
    localparam int DEF_ROWS    = 45;
    localparam int DEF_HOLDOFF = 2;

    // Assemble {x, y, num} into a command data word.
    function automatic logic [47:0] pack_data(input logic [7:0] x,
                                              input logic [7:0] y,
                                              input logic [31:0] num);
        logic [47:0] d;
        d = '0;
        d[X_MSB:X_LSB]     = x;
        d[Y_MSB:Y_LSB]     = y;
        d[NUM_MSB:NUM_LSB] = num;
        return d;
    endfunction

endpackage

// File: rtl/cmd_issuer.sv
// Registered command/data output stage with post-issue holdoff.
// A requesting state fires on the first edge where the display is ready
// and the holdoff has expired; cmd is then a single-cycle pulse.
module cmd_issuer
    import display_pkg::*;
#(
    parameter int HOLDOFF = DEF_HOLDOFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_req,
    input  cmd_e        issue_cmd,
    input  logic [47:0] issue_data,
    input  logic        disp_ready,
    output logic [3:0]  cmd,
    output logic [47:0] data,
    output logic        fire
);

    localparam int HW = $clog2(HOLDOFF + 2);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF);

    logic [HW-1:0] holdoff;

    // The display's ready flag lags our own cmd, so it is ignored while holdoff runs.
    assign fire = issue_req && disp_ready && (holdoff == '0);

    // Load cmd/data on an issue; otherwise drop cmd to NOP, keep data, count holdoff down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd     <= CMD_NOP;
            data    <= '0;
            holdoff <= '0;
        end else if (fire) begin
            cmd     <= issue_cmd;
            data    <= issue_data;
            holdoff <= HOLD_LOAD;
        end else begin
            cmd <= CMD_NOP;
            if (holdoff != '0) begin
                holdoff <= holdoff - HW'(1);
            end
        end
    end

endmodule

// File: rtl/number_console.sv
// Number console: places signed 32-bit values into fixed-width cells on the
// display text grid, tracking the cursor and scrolling past the bottom row.
module number_console
    import display_pkg::*;
#(
    parameter int COLS    = DEF_COLS,
    parameter int ROWS    = DEF_ROWS,
    parameter int HOLDOFF = DEF_HOLDOFF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic               in_newline,
    input  logic signed [31:0] in_data,
    output logic               in_ready,
    output logic [3:0]         cmd,
    output logic [47:0]        data,
    input  logic               disp_ready,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_NUMBER, S_ADVANCE, S_NEWLINE, S_SCROLL
    } state_e;

    localparam logic [7:0] LAST_COL = 8'(COLS - 1);
    localparam logic [7:0] LAST_ROW = 8'(ROWS - 1);

    state_e             state, state_d;
    logic [7:0]         col, row;
    logic signed [31:0] value;
    logic               accept;
    logic               issue_req, fire;
    cmd_e               issue_cmd;
    logic [47:0]        issue_data;

    assign accept = in_valid && in_ready;
    assign busy   = (state != S_IDLE);

    cmd_issuer #(.HOLDOFF(HOLDOFF)) u_issuer (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_req  (issue_req),
        .issue_cmd  (issue_cmd),
        .issue_data (issue_data),
        .disp_ready (disp_ready),
        .cmd        (cmd),
        .data       (data),
        .fire       (fire)
    );

    // Next-state and issue request selection.
    always_comb begin
        state_d    = state;
        issue_req  = 1'b0;
        issue_cmd  = CMD_NOP;
        issue_data = '0;
        case (state)
            S_IDLE: begin
                if (accept) state_d = in_newline ? S_NEWLINE : S_CLEAR;
            end
            S_CLEAR: begin
                issue_req  = 1'b1;
                issue_cmd  = CMD_POS_CLEAR;
                issue_data = pack_data(col, row, 32'd0);
                if (fire) state_d = S_NUMBER;
            end
            S_NUMBER: begin
                issue_req  = 1'b1;
                issue_cmd  = CMD_NUMBER;
                issue_data = pack_data(col, row, value);
                if (fire) state_d = S_ADVANCE;
            end
            S_ADVANCE: begin
                state_d = (col == LAST_COL) ? S_NEWLINE : S_IDLE;
            end
            S_NEWLINE: begin
                state_d = (row == LAST_ROW) ? S_SCROLL : S_IDLE;
            end
            S_SCROLL: begin
                issue_req  = 1'b1;
                issue_cmd  = CMD_SCROLL;
                issue_data = '0;
                if (fire) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, handshake, latched value and cursor registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            value    <= '0;
            col      <= '0;
            row      <= '0;
        end else begin
            state    <= state_d;
            // Registered so it stays low while reset is held and rises on the first edge after.
            in_ready <= (state_d == S_IDLE);
            if (accept && !in_newline) begin
                value <= in_data;
            end
            if (state == S_ADVANCE && col != LAST_COL) begin
                col <= col + 8'd1;
            end
            if (state == S_NEWLINE) begin
                col <= '0;
                // On the bottom row the row stays put and the display scrolls instead.
                if (row != LAST_ROW) row <= row + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_number_console.sv
// Directed bench for number_console with a display model and an expected-command scoreboard.
module tb_number_console;
    import display_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_newline = 1'b0;
    logic signed [31:0] in_data = '0;
    logic               in_ready;
    logic [3:0]         cmd;
    logic [47:0]        data;
    logic               disp_ready;
    logic               busy;

    int errors = 0;
    int checks = 0;

    // Display model: busy for disp_dly cycles after seeing a command.
    int disp_cnt = 0;
    int disp_dly = 3;
    bit disp_hold = 1'b0;

    logic [51:0] sb[$];
    logic [51:0] mon_exp;
    logic [3:0]  prev_cmd = 4'd0;
    int m_col = 0;
    int m_row = 0;

    always #5 clk = ~clk;

    assign disp_ready = !disp_hold && (disp_cnt == 0) && (cmd == 4'd0);

    always @(posedge clk) begin
        if (cmd != 4'd0) disp_cnt <= disp_dly;
        else if (disp_cnt > 0) disp_cnt <= disp_cnt - 1;
    end

    number_console dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_newline (in_newline),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .cmd        (cmd),
        .data       (data),
        .disp_ready (disp_ready),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [51:0] ent(input logic [3:0] c, input int x, input int y,
                                        input logic [31:0] n);
        return {c, 8'(x), 8'(y), n};
    endfunction

    // Compare each issued command against the oldest expectation.
    always @(negedge clk) begin
        if (cmd != 4'd0) begin
            check("cmd_pulse_width", {60'd0, prev_cmd}, 64'd0);
            if (sb.size() == 0) begin
                check("unexpected_cmd", {12'd0, cmd, data}, 64'd0);
            end else begin
                mon_exp = sb.pop_front();
                check("cmd_data", {12'd0, cmd, data}, {12'd0, mon_exp});
            end
        end
        prev_cmd = cmd;
    end

    task automatic model_newline();
        m_col = 0;
        if (m_row == 44) sb.push_back(ent(4'd1, 0, 0, 32'd0));
        else m_row++;
    endtask

    task automatic push(input bit nl, input logic signed [31:0] v);
        int n;
        n = 0;
        if (nl) begin
            model_newline();
        end else begin
            sb.push_back(ent(4'd2, m_col, m_row, 32'd0));
            sb.push_back(ent(4'd3, m_col, m_row, v));
            if (m_col == 12) model_newline();
            else m_col++;
        end
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
        in_valid   = 1'b1;
        in_newline = nl;
        in_data    = v;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_newline = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!(sb.size() == 0 && !busy && in_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", {63'd0, (sb.size() == 0 && !busy && in_ready)}, 64'd1);
    endtask

    initial begin
        logic seen_cmd, seen_rdy, seen_idle;
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd", {60'd0, cmd}, 64'd0);
        check("rst_data", {16'd0, data}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        rst_n = 1'b1;
        #1;
        check("in_ready_before_edge", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        check("in_ready_after_release", {63'd0, in_ready}, 64'd1);

        // First number: POS CLEAR one cycle after accept, then NUMBER
        push(1'b0, 32'sd1234);
        @(negedge clk);
        check("clear_not_early", {60'd0, cmd}, 64'd0);
        @(negedge clk);
        check("clear_latency", {60'd0, cmd}, 64'd2);
        wait_idle();
        check("col_after_first", {56'd0, dut.col}, 64'd1);
        check("row_after_first", {56'd0, dut.row}, 64'd0);

        // Reset while waiting to issue NUMBER
        push(1'b0, 32'sd99);
        n = 0;
        while (sb.size() > 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_cmd", {60'd0, cmd}, 64'd0);
        check("midrst_data", {16'd0, data}, 64'd0);
        check("midrst_col", {56'd0, dut.col}, 64'd0);
        check("midrst_row", {56'd0, dut.row}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
        sb.delete();
        m_col = 0;
        m_row = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_in_ready_release", {63'd0, in_ready}, 64'd1);

        // A full row of -7: cells 0..12 on row 0, wrap to row 1 without scroll
        for (int i = 0; i < 13; i++) begin
            push(1'b0, -32'sd7);
            wait_idle();
        end
        check("wrap_col", {56'd0, dut.col}, 64'd0);
        check("wrap_row", {56'd0, dut.row}, 64'd1);

        // Newline mid-row issues nothing and advances the row
        push(1'b0, 32'sd1);
        push(1'b0, -32'sd2);
        push(1'b0, 32'sd3);
        wait_idle();
        push(1'b1, 32'sd0);
        wait_idle();
        check("nl_col", {56'd0, dut.col}, 64'd0);
        check("nl_row", {56'd0, dut.row}, 64'd2);

        // Empty lines down to the bottom row, then one more scrolls once
        for (int i = 0; i < 42; i++) begin
            push(1'b1, 32'sd0);
        end
        wait_idle();
        check("bottom_row", {56'd0, dut.row}, 64'd44);
        push(1'b1, 32'sd0);
        wait_idle();
        check("nl_scroll_row", {56'd0, dut.row}, 64'd44);
        check("nl_scroll_col", {56'd0, dut.col}, 64'd0);

        // Fill the bottom row; the last cell wraps and scrolls
        for (int i = 0; i < 12; i++) begin
            if (i == 4) push(1'b0, 32'sh7fffffff);
            else if (i == 5) push(1'b0, 32'sh80000000);
            else push(1'b0, 32'(i * 1000 - 3000));
            wait_idle();
        end
        push(1'b0, 32'sd5);
        wait_idle();
        check("last_cell_col", {56'd0, dut.col}, 64'd0);
        check("last_cell_row", {56'd0, dut.row}, 64'd44);

        // Display stalled for 500 cycles after accept
        disp_hold = 1'b1;
        push(1'b0, -32'sd42);
        seen_cmd  = 1'b0;
        seen_rdy  = 1'b0;
        seen_idle = 1'b0;
        repeat (500) begin
            @(negedge clk);
            if (cmd != 4'd0) seen_cmd = 1'b1;
            if (in_ready) seen_rdy = 1'b1;
            if (!busy) seen_idle = 1'b1;
        end
        check("stall_cmd_zero", {63'd0, seen_cmd}, 64'd0);
        check("stall_in_ready_low", {63'd0, seen_rdy}, 64'd0);
        check("stall_busy_high", {63'd0, seen_idle}, 64'd0);
        disp_hold = 1'b0;
        @(negedge clk);
        check("stall_release_issue", {60'd0, cmd}, 64'd2);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
